// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, ALU function codes, FSM states and CCR bit positions
package alu_sequencer_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LSL = 4'h2;
    localparam logic [3:0] OP_LSR = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_COM = 4'h5;
    localparam logic [3:0] OP_NEG = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_BRN = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hA;
    localparam logic [3:0] OP_BRV = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;

    localparam int CCR_N = 2;
    localparam int CCR_V = 1;
    localparam int CCR_Z = 0;

    typedef enum logic [2:0] {F_ADD, F_SUB, F_LSL, F_LSR, F_XOR, F_COM, F_NEG, F_CLR} alu_fn_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, ALU operand/result wires and retire status
interface alu_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OPW = 4
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_f;
    logic [WIDTH-1:0] alu_y;
    logic             alu_n;
    logic             alu_v;
    logic             alu_z;
    logic [WIDTH-1:0] acc;
    logic [2:0]       ccr;
    logic             done;
    logic             br_taken;

    modport master (
        output instr_valid, opcode, imm, alu_y, alu_n, alu_v, alu_z,
        input  instr_ready, alu_a, alu_b, alu_f, acc, ccr, done, br_taken
    );

    modport slave (
        input  instr_valid, opcode, imm, alu_y, alu_n, alu_v, alu_z,
        output instr_ready, alu_a, alu_b, alu_f, acc, ccr, done, br_taken
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction to the combinational ALU every three cycles
// and writes the result back into the accumulator and condition-code register.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW = 4
) (
    input logic clk,
    input logic reset,
    alu_sequencer_if.slave bus
);
    state_e state, next;
    logic [OPW-1:0] op;
    logic [WIDTH-1:0] imm_q;
    logic br_q;
    logic accept;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;

    always_comb begin
        bus.instr_ready = state == IDLE && !reset;
        accept = bus.instr_valid && bus.instr_ready;
        bus.done = state == DONE;
        bus.br_taken = state == DONE && br_q;
        next = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? DONE : IDLE;
    end

    // ALU outputs are valid during EXEC, so writeback happens on the edge leaving it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op <= '0;
            imm_q <= '0;
            br_q <= 1'b0;
            bus.acc <= '0;
            bus.ccr <= '0;
            bus.alu_a <= '0;
            bus.alu_b <= '0;
            bus.alu_f <= '0;
        end else if (accept) begin
            op <= bus.opcode;
            imm_q <= bus.imm;
            br_q <= 1'b0;
            bus.alu_a <= bus.acc;
            bus.alu_b <= bus.imm;
            bus.alu_f <= bus.opcode == OP_CMP ? F_SUB : bus.opcode[2:0];
        end else if (state == EXEC) begin
            br_q <= (op == OP_BRN && bus.ccr[CCR_N]) ||
                    (op == OP_BRZ && bus.ccr[CCR_Z]) ||
                    (op == OP_BRV && bus.ccr[CCR_V]);
            if (op == OP_LDI) begin
                bus.acc <= imm_q;
                bus.ccr <= {imm_q[WIDTH-1], 1'b0, imm_q == '0};
            end else if (!op[OPW-1]) begin
                bus.acc <= bus.alu_y;
                bus.ccr <= {bus.alu_n, bus.alu_v, bus.alu_z};
            end else if (op == OP_CMP) begin
                bus.ccr <= {bus.alu_n, bus.alu_v, bus.alu_z};
            end
        end
    end
endmodule
